tetris_score_engine: RTL
========================

# tetris_score_engine

Parametrised successor to the game's score/level tracker. It consumes line-clear and drop events from the playfield controller through valid-qualified inputs. It keeps a saturating score, a total-lines count, and the level derived from that count, and it runs the IDLE/PLAYING/GAME_OVER game state machine. It also drives the gravity period used by the piece-fall timer, and sits between the playfield controller and the display/seven-segment formatter.

## Interface
- SCORE_W, 20: score and high-score width in bits.
- LEVEL_W, 4: level width in bits.
- MAX_LEVEL, 15: level ceiling; must be less than 2^LEVEL_W.
- LINES_PER_LEVEL, 10: lines needed per level step.
- BASE_PERIOD, 60: drop period at level 0, in gravity ticks.
- PERIOD_STEP, 4: period reduction per level.
- MIN_PERIOD, 4: period floor.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts or restarts a game.
- clear_valid  in  1  a line-clear event is presented this cycle.
- clear_rows  in  3  number of rows cleared, 0..4; values above 4 are treated as 4.
- drop_valid  in  1  a soft-drop event is presented this cycle.
- drop_cells  in  5  cells dropped; scores 1 point per cell.
- spawn_blocked  in  1  the new piece collides at spawn.
- score  out  SCORE_W  current score.
- level  out  LEVEL_W  current level.
- lines_total  out  16  lines cleared this game; saturates at 16'hFFFF.
- drop_period  out  8  gravity period for the fall timer.
- playing  out  1  the state machine is in PLAYING.
- game_over  out  1  the state machine is in GAME_OVER.
- level_up  out  1  one-cycle pulse on each level increment.
- hiscore  out  SCORE_W  best score seen (present only with the macro, see Configuration).

## Operation
- FSM states:
  - IDLE→PLAYING on start.
  - PLAYING→GAME_OVER on spawn_blocked.
  - GAME_OVER→PLAYING on start.
  - PLAYING→PLAYING on start: restart.
- Entry into PLAYING zeroes score, level, lines_total and the pipeline.
- Events (clear_valid, drop_valid) are accepted only in PLAYING. They are ignored in IDLE and GAME_OVER, and in the cycle start is asserted.
- Line-clear base table, indexed by rows 0/1/2/3/4: 0/40/100/300/1200. The base is multiplied by (level+1), using the level at the event cycle, before any increment.
- Points for an event = clear points + (drop_valid ? drop_cells : 0). A clear and a drop in the same cycle are summed.
- Score addition saturates at 2^SCORE_W−1 and never wraps.
- Level = min(MAX_LEVEL, lines_total / LINES_PER_LEVEL). It is computed with a running lines-in-level counter, not a divider.
- A single clear that crosses a threshold raises level by at most 1. The remainder carries into the counter.
- level_up pulses for exactly one cycle whenever level increments. It does not pulse once level is at MAX_LEVEL.
- drop_period = max(MIN_PERIOD, BASE_PERIOD − level×PERIOD_STEP), computed without unsigned underflow.
- spawn_blocked in the same cycle as an event: the event is still scored, and the pipeline drains in GAME_OVER.
- spawn_blocked outside PLAYING is ignored.

## Timing
- Reset values:
  - score=0, level=0, lines_total=0, level_up=0, hiscore=0.
  - drop_period=BASE_PERIOD.
  - playing=0, game_over=0; the FSM is in IDLE.
- Two-stage score pipeline:
  - Stage 1 registers points (SCORE_W bits).
  - Stage 2 registers score ← sat(score + points).
  - score reflects an event accepted in cycle N at cycle N+2.
  - Back-to-back events every cycle are supported; there is no backpressure.
- lines_total, level and level_up update at N+1. drop_period updates at N+2.
- playing and game_over change in the cycle after the triggering input.
- Restart (start) clears both pipeline stages, so no in-flight points land in the new game.
- Asynchronous reset mid-pipeline discards in-flight points.

## Configuration
- TETRIS_HISCORE_EN defined:
  - A hiscore register and port exist.
  - On every transition into GAME_OVER, hiscore ← max(hiscore, final score). The final score includes points still draining, so the update is taken at the transition +2 cycles.
  - hiscore survives start; only reset_n clears it.
- TETRIS_HISCORE_EN undefined: the port and register are absent. All other behaviour is identical.

## Structure
- Package tetris_pkg holds:
  - the game_state_t enum (IDLE, PLAYING, GAME_OVER);
  - the line-clear base table constants;
  - the clear_rows width constant.
- One sub-module, tetris_level_ctrl, covers:
  - lines-in-level counter, level, level_up and drop_period;
  - inputs: clock, reset_n, restart, rows_valid, rows.

## Test plan
- Reset, then start, then clear_valid with rows=1 at level 0 → score=40 two cycles later; lines_total=1.
- Ten single-row clears, then one 4-row clear → level_up pulses once after the 10th clear, level=1. The 4-row clear scores 1200×2=2400, and lines_total=14.
- clear_rows=2 and drop_cells=7 in the same cycle at level 0 → score increments by 107.
- Preload score to 2^SCORE_W−100, then a 4-row clear → score saturates at 2^SCORE_W−1.
- spawn_blocked at score 500 → game_over=1 next cycle; later events are ignored. Then start → score=0, playing=1, and hiscore=500 (with the macro).
- Drive the level to MAX_LEVEL with defaults → drop_period=MIN_PERIOD=4, and no level_up pulse on further clears.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared game-state encoding and line-clear scoring constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tetris_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PLAYING   = 2'd1,
      GAME_OVER = 2'd2
   } game_state_t;

   // Width of the clear_rows field and the largest row count that scores.
   localparam int ROWS_W   = 3;
   localparam int MAX_ROWS = 4;

   // Base points for a clear, before the (level+1) multiplier.
   localparam int unsigned CLEAR_PTS_0 = 0;
   localparam int unsigned CLEAR_PTS_1 = 40;
   localparam int unsigned CLEAR_PTS_2 = 100;
   localparam int unsigned CLEAR_PTS_3 = 300;
   localparam int unsigned CLEAR_PTS_4 = 1200;

   // Rows are expected to be clamped to MAX_ROWS already; larger codes map to a tetris.
   function automatic int unsigned clear_base(input logic [ROWS_W-1:0] rows);
      case (rows)
         3'd0:    return CLEAR_PTS_0;
         3'd1:    return CLEAR_PTS_1;
         3'd2:    return CLEAR_PTS_2;
         3'd3:    return CLEAR_PTS_3;
         default: return CLEAR_PTS_4;
      endcase
   endfunction

endpackage

// File: rtl/tetris_level_ctrl.sv
// Level tracker: lines-in-level counter, level, level_up pulse and gravity period.
// Latency: level/level_up one cycle after a clear; drop_period one cycle after level.
// Backpressure: none; accepts a clear every cycle.
module tetris_level_ctrl
   import tetris_pkg::*;
#(
   parameter int LEVEL_W         = 4,
   parameter int MAX_LEVEL       = 15,
   parameter int LINES_PER_LEVEL = 10,
   parameter int BASE_PERIOD     = 60,
   parameter int PERIOD_STEP     = 4,
   parameter int MIN_PERIOD      = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               restart,
   input  logic               rows_valid,
   input  logic [ROWS_W-1:0]  rows,
   output logic [LEVEL_W-1:0] level,
   output logic               level_up,
   output logic [7:0]         drop_period
);

   // Counter must hold the largest pre-wrap sum: (LINES_PER_LEVEL-1) + MAX_ROWS.
   localparam int CNT_W = $clog2(LINES_PER_LEVEL + MAX_ROWS + 1);

   logic [CNT_W-1:0] lil_q;
   logic [CNT_W-1:0] lil_sum;
   logic             at_max;
   logic [7:0]       period_nxt;
   int               reduction;

   // Running lines-in-level sum and ceiling detect; replaces a lines/LINES_PER_LEVEL divider.
   always_comb begin
      lil_sum = lil_q + CNT_W'(rows);
      at_max  = (level == LEVEL_W'(MAX_LEVEL));
   end

   // One level step at most per clear; the overshoot carries into the counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lil_q    <= '0;
         level    <= '0;
         level_up <= 1'b0;
      end else if (restart) begin
         lil_q    <= '0;
         level    <= '0;
         level_up <= 1'b0;
      end else begin
         level_up <= 1'b0;
         if (rows_valid && !at_max) begin
            if (lil_sum >= CNT_W'(LINES_PER_LEVEL)) begin
               lil_q    <= lil_sum - CNT_W'(LINES_PER_LEVEL);
               level    <= level + LEVEL_W'(1);
               level_up <= 1'b1;
            end else begin
               lil_q <= lil_sum;
            end
         end
      end
   end

   // Period floor is tested before subtracting so the result never underflows.
   always_comb begin
      reduction = int'(level) * PERIOD_STEP;
      if (BASE_PERIOD <= MIN_PERIOD + reduction)
         period_nxt = 8'(MIN_PERIOD);
      else
         period_nxt = 8'(BASE_PERIOD - reduction);
   end

   // Period is registered from the already-registered level, hence one extra cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         drop_period <= 8'(BASE_PERIOD);
      else
         drop_period <= period_nxt;
   end

endmodule

// File: rtl/tetris_score_engine.sv
// Score/level/game-state engine; optional hiscore register under TETRIS_HISCORE_EN.
// Latency: score N+2 after an accepted event; lines/level/level_up N+1; drop_period N+2.
// Backpressure: none; one clear and one drop accepted per cycle while PLAYING.
module tetris_score_engine
   import tetris_pkg::*;
#(
   parameter int SCORE_W         = 20,
   parameter int LEVEL_W         = 4,
   parameter int MAX_LEVEL       = 15,
   parameter int LINES_PER_LEVEL = 10,
   parameter int BASE_PERIOD     = 60,
   parameter int PERIOD_STEP     = 4,
   parameter int MIN_PERIOD      = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               clear_valid,
   input  logic [ROWS_W-1:0]  clear_rows,
   input  logic               drop_valid,
   input  logic [4:0]         drop_cells,
   input  logic               spawn_blocked,
   output logic [SCORE_W-1:0] score,
   output logic [LEVEL_W-1:0] level,
   output logic [15:0]        lines_total,
   output logic [7:0]         drop_period,
   output logic               playing,
   output logic               game_over,
   output logic               level_up
`ifdef TETRIS_HISCORE_EN
   ,
   output logic [SCORE_W-1:0] hiscore
`endif
);

   localparam logic [63:0] SCORE_MAX = (64'd1 << SCORE_W) - 64'd1;

   game_state_t        state_q, state_d;
   logic               accept, clr_acc, drp_acc;
   logic [ROWS_W-1:0]  rows_eff;
   logic [63:0]        evt_pts;
   logic [SCORE_W-1:0] pts_d, pts_q;
   logic [SCORE_W:0]   score_sum;
   logic [SCORE_W-1:0] score_nxt;
   logic [16:0]        lines_sum;

   // Game state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state: start always (re)enters PLAYING and wins over spawn_blocked.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (start) state_d = PLAYING;
         PLAYING:   if (start) state_d = PLAYING;
                    else if (spawn_blocked) state_d = GAME_OVER;
         GAME_OVER: if (start) state_d = PLAYING;
         default:   state_d = IDLE;
      endcase
   end

   assign playing   = (state_q == PLAYING);
   assign game_over = (state_q == GAME_OVER);

   // Event qualification and stage-1 points, priced at the pre-increment level.
   always_comb begin
      accept   = playing && !start;
      clr_acc  = clear_valid && accept;
      drp_acc  = drop_valid && accept;
      rows_eff = (clear_rows > ROWS_W'(MAX_ROWS)) ? ROWS_W'(MAX_ROWS) : clear_rows;
      evt_pts  = 64'd0;
      if (clr_acc)
         evt_pts = 64'(clear_base(rows_eff)) * (64'(level) + 64'd1);
      if (drp_acc)
         evt_pts = evt_pts + 64'(drop_cells);
      pts_d     = (evt_pts > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : evt_pts[SCORE_W-1:0];
      score_sum = {1'b0, score} + {1'b0, pts_q};
      score_nxt = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
      lines_sum = {1'b0, lines_total} + 17'(rows_eff);
   end

   // Two-stage score pipeline; start flushes both stages so nothing leaks into a new game.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pts_q <= '0;
         score <= '0;
      end else if (start) begin
         pts_q <= '0;
         score <= '0;
      end else begin
         pts_q <= pts_d;
         score <= score_nxt;
      end
   end

   // Saturating lines-this-game counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         lines_total <= '0;
      else if (start)
         lines_total <= '0;
      else if (clr_acc)
         lines_total <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
   end

   tetris_level_ctrl #(
      .LEVEL_W         (LEVEL_W),
      .MAX_LEVEL       (MAX_LEVEL),
      .LINES_PER_LEVEL (LINES_PER_LEVEL),
      .BASE_PERIOD     (BASE_PERIOD),
      .PERIOD_STEP     (PERIOD_STEP),
      .MIN_PERIOD      (MIN_PERIOD)
   ) u_level_ctrl (
      .clock       (clock),
      .reset_n     (reset_n),
      .restart     (start),
      .rows_valid  (clr_acc),
      .rows        (rows_eff),
      .level       (level),
      .level_up    (level_up),
      .drop_period (drop_period)
   );

`ifdef TETRIS_HISCORE_EN
   logic go_d;

   // One cycle after entering GAME_OVER, score_nxt holds the fully drained final score.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         go_d    <= 1'b0;
         hiscore <= '0;
      end else begin
         go_d <= playing && (state_d == GAME_OVER);
         if (go_d && (score_nxt > hiscore))
            hiscore <= score_nxt;
      end
   end
`endif

endmodule
